// File: rtl/bus_matrix.sv
`default_nettype none
// ============================================================================
// Module   : bus_matrix
// Purpose  : Single-master address decoder and bus matrix with per-slave wait
//            states, open-bus read latch and a page-copy DMA engine. A core
//            write to the trigger address starts a 256-byte copy from page P
//            to a fixed destination, during which the core is stalled.
// Ports    : I_clock, I_reset        - clock, synchronous active-high reset
//            I_core_*                - core address/strobe/direction/data
//            O_core_rd_data/ready    - read data and stall (0 = stall)
//            O_slv_select/addr/...   - one-hot select, address, strobes, data
//            I_slv_rd_data/drive     - per-slave read data and drive flags
//            O_dma_busy              - DMA engine owns the bus
// Revision : 1.0 - initial release
// ============================================================================
module bus_matrix #(
  parameter int                    P_slaves      = 3,
  parameter logic [63:0]           P_slot_map    = 64'h2222_2222_2222_1100,
  parameter logic [P_slaves*4-1:0] P_wait        = '0,
  parameter logic [15:0]           P_dma_trigger = 16'h4014,
  parameter logic [15:0]           P_dma_dest    = 16'h2004
) (
  input  logic                  I_clock,
  input  logic                  I_reset,
  input  logic [15:0]           I_core_addr,
  input  logic                  I_core_rdwr,
  input  logic                  I_core_phy2,
  input  logic [7:0]            I_core_wr_data,
  output logic [7:0]            O_core_rd_data,
  output logic                  O_core_ready,
  output logic [P_slaves-1:0]   O_slv_select,
  output logic [15:0]           O_slv_addr,
  output logic                  O_slv_wren,
  output logic                  O_slv_rden,
  output logic [7:0]            O_slv_wr_data,
  input  logic [P_slaves*8-1:0] I_slv_rd_data,
  input  logic [P_slaves-1:0]   I_slv_drive,
  output logic                  O_dma_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HALT  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          page, cnt, dma_data, open_bus;
  logic [3:0]          wait_cnt;

  logic                idle;
  logic [15:0]         bus_addr;
  logic [7:0]          bus_wdata;
  logic [3:0]          slot_idx;
  logic [3:0]          wait_sel;
  logic [P_slaves-1:0] select;
  logic [7:0]          rd_mux;
  logic                access, is_read, final_cycle;
  logic [7:0]          bus_data;
  logic                trigger_hit;

  assign idle = (state == S_IDLE);

  // Address/data source: core while idle, DMA engine otherwise.
  always_comb begin
    bus_addr  = I_core_addr;
    bus_wdata = I_core_wr_data;
    if (!idle) begin
      bus_addr  = (state == S_WRITE) ? P_dma_dest : {page, cnt};
      bus_wdata = dma_data;
    end
  end

  assign slot_idx = P_slot_map[{bus_addr[15:12], 2'b00} +: 4];

  // Decode, wait lookup and read mux. A slot index with no matching slave
  // selects nothing, has no wait states and reads the open-bus latch.
  always_comb begin
    select   = '0;
    wait_sel = '0;
    rd_mux   = open_bus;
    for (int i = 0; i < P_slaves; i++) begin
      if (slot_idx == 4'(i)) begin
        select[i] = 1'b1;
        wait_sel  = P_wait[4*i +: 4];
        if (I_slv_drive[i]) rd_mux = I_slv_rd_data[8*i +: 8];
      end
    end
  end

  assign access  = idle ? I_core_phy2 : ((state == S_READ) || (state == S_WRITE));
  assign is_read = idle ? I_core_rdwr : (state == S_READ);
  // ">=" keeps a core that changes address mid-wait from stalling forever.
  assign final_cycle = access && (wait_cnt >= wait_sel);
  assign bus_data    = is_read ? rd_mux : bus_wdata;
  assign trigger_hit = idle && final_cycle && !I_core_rdwr &&
                       (I_core_addr == P_dma_trigger);

  // Outputs are gated by reset so that strobes stop in the reset cycle itself.
  assign O_slv_select   = select;
  assign O_slv_addr     = bus_addr;
  assign O_slv_wr_data  = bus_wdata;
  assign O_core_rd_data = rd_mux;
  assign O_slv_rden     = !I_reset && access && is_read;
  assign O_slv_wren     = !I_reset && access && !is_read && final_cycle;
  assign O_core_ready   = I_reset || (idle && (!I_core_phy2 || final_cycle));
  assign O_dma_busy     = !I_reset && !idle;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger_hit) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_READ;
      S_READ:  if (final_cycle) state_nxt = S_WRITE;
      S_WRITE: if (final_cycle) state_nxt = (cnt == 8'hFF) ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state    <= S_IDLE;
      page     <= 8'h00;
      cnt      <= 8'h00;
      dma_data <= 8'h00;
      open_bus <= 8'h00;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (access && !final_cycle) wait_cnt <= wait_cnt + 4'd1;
      else                        wait_cnt <= 4'd0;
      if (final_cycle) open_bus <= bus_data;
      if (trigger_hit) begin
        page <= I_core_wr_data;
        cnt  <= 8'h00;
      end
      if ((state == S_READ) && final_cycle) dma_data <= rd_mux;
      // The counter stops at 255; the copy ends instead of wrapping.
      if ((state == S_WRITE) && final_cycle && (cnt != 8'hFF)) cnt <= cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_matrix
// Purpose  : Self-checking bench for bus_matrix. Stimulus pushes expected
//            slave writes, DMA read addresses and core read data into queues;
//            a negedge monitor pops and compares whenever the DUT presents
//            the corresponding event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_matrix;

  localparam int          NS    = 3;
  localparam logic [63:0] MAP   = 64'h2222_2222_F222_1100; // page 7 unmapped
  localparam logic [11:0] WAITS = 12'h300;                 // slave 2: 3 waits
  localparam logic [15:0] TRIG  = 16'h4014;
  localparam logic [15:0] DEST  = 16'h2004;

  typedef struct packed {
    logic [15:0]   addr;
    logic [7:0]    data;
    logic [NS-1:0] sel;
  } wr_t;

  logic              clk, rst;
  logic [15:0]       core_addr;
  logic              core_rdwr, core_phy2;
  logic [7:0]        core_wdata, core_rdata;
  logic              core_ready;
  logic [NS-1:0]     slv_select;
  logic [15:0]       slv_addr;
  logic              slv_wren, slv_rden;
  logic [7:0]        slv_wdata;
  logic [NS*8-1:0]   slv_rd_data;
  logic [NS-1:0]     drv;
  logic              dma_busy;

  logic [7:0]        rom [0:1023];
  wr_t               wr_q[$];
  logic [15:0]       dma_rd_q[$];
  logic [7:0]        rd_q[$];
  logic [7:0]        ob;     // model of the open-bus latch
  int                tests = 0;
  int                fails = 0;

  bus_matrix #(
    .P_slaves(NS), .P_slot_map(MAP), .P_wait(WAITS),
    .P_dma_trigger(TRIG), .P_dma_dest(DEST)
  ) dut (
    .I_clock(clk), .I_reset(rst),
    .I_core_addr(core_addr), .I_core_rdwr(core_rdwr), .I_core_phy2(core_phy2),
    .I_core_wr_data(core_wdata),
    .O_core_rd_data(core_rdata), .O_core_ready(core_ready),
    .O_slv_select(slv_select), .O_slv_addr(slv_addr),
    .O_slv_wren(slv_wren), .O_slv_rden(slv_rden), .O_slv_wr_data(slv_wdata),
    .I_slv_rd_data(slv_rd_data), .I_slv_drive(drv),
    .O_dma_busy(dma_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running");
    $fatal(1, "timeout");
  end

  // Slave 0 is a ROM; slaves 1 and 2 return an address hash.
  function automatic logic [7:0] slave_val(int i, logic [15:0] a);
    if (i == 0) return rom[a[9:0]];
    return a[7:0] ^ a[15:8] ^ 8'(i * 60);
  endfunction

  assign slv_rd_data[7:0]   = rom[slv_addr[9:0]];
  assign slv_rd_data[15:8]  = slv_addr[7:0] ^ slv_addr[15:8] ^ 8'd60;
  assign slv_rd_data[23:16] = slv_addr[7:0] ^ slv_addr[15:8] ^ 8'd120;

  // Reference decode: slave index of the page, -1 when none exists.
  function automatic int model_sel(logic [15:0] a);
    int idx;
    idx = int'((MAP >> (4 * a[15:12])) & 64'hF);
    return (idx < NS) ? idx : -1;
  endfunction

  function automatic logic [NS-1:0] model_onehot(logic [15:0] a);
    int s;
    s = model_sel(a);
    return (s < 0) ? '0 : NS'(1 << s);
  endfunction

  function automatic int model_wait(logic [15:0] a);
    int s;
    s = model_sel(a);
    return (s < 0) ? 0 : int'((WAITS >> (4 * s)) & 12'hF);
  endfunction

  function automatic logic [7:0] model_read(logic [15:0] a);
    int s;
    s = model_sel(a);
    return (s >= 0 && drv[s]) ? slave_val(s, a) : ob;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One core access; checks per-cycle strobes and the access length.
  task automatic core_access(logic [15:0] a, logic rd, logic [7:0] d);
    int  w, cyc;
    bit  done;
    w = model_wait(a);
    if (rd) begin
      ob = model_read(a);
      rd_q.push_back(ob);
    end else begin
      wr_q.push_back('{addr: a, data: d, sel: model_onehot(a)});
      ob = d;
    end
    @(posedge clk); #1;
    core_addr = a; core_rdwr = rd; core_wdata = d; core_phy2 = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      done = core_ready;
      check("rden", slv_rden, rd);
      check("wren", slv_wren, !rd && (cyc == w + 1));
    end
    check("access_cycles", cyc, w + 1);
    @(posedge clk); #1;
    core_phy2 = 1'b0;
  endtask

  // Expected traffic of a full page copy.
  task automatic push_dma(logic [7:0] p);
    logic [15:0] a;
    for (int c = 0; c < 256; c++) begin
      a = {p, 8'(c)};
      ob = model_read(a);
      dma_rd_q.push_back(a);
      wr_q.push_back('{addr: DEST, data: ob, sel: model_onehot(DEST)});
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    wr_t         e;
    logic [15:0] ea;
    logic [7:0]  ed;
    if (!rst) begin
      if (slv_wren) begin
        check("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("wr_addr", slv_addr, e.addr);
          check("wr_data", slv_wdata, e.data);
          check("wr_sel",  slv_select, e.sel);
        end
      end
      if (dma_busy && slv_rden) begin
        check("dma_rd_expected", dma_rd_q.size() > 0, 1);
        if (dma_rd_q.size() > 0) begin
          ea = dma_rd_q.pop_front();
          check("dma_rd_addr", slv_addr, ea);
        end
      end
      if (!dma_busy && core_phy2 && core_rdwr && core_ready) begin
        check("rd_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          ed = rd_q.pop_front();
          check("rd_data", core_rdata, ed);
        end
      end
    end
  end

  initial begin
    int          n, ready_bad;
    logic [15:0] a;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[10'h123] = 8'h5A;
    rst = 1'b1; drv = 3'b111; ob = 8'h00;
    core_addr = 16'h0123; core_rdwr = 1'b1; core_phy2 = 1'b1; core_wdata = 8'h00;

    // Reset with a live core read, then a live trigger write.
    @(negedge clk);
    check("rst_ready", core_ready, 1);
    check("rst_busy",  dma_busy, 0);
    check("rst_rden",  slv_rden, 0);
    core_addr = TRIG; core_rdwr = 1'b0; core_wdata = 8'h02;
    @(negedge clk);
    check("rst_wren",  slv_wren, 0);
    @(posedge clk); #1;
    core_phy2 = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", dma_busy, 0);

    // Directed decode, waits and open bus.
    drv = 3'b001;
    core_access(16'h0123, 1'b1, 8'h00);      // slave 0, data 5A, no stall
    core_access(16'h8000, 1'b0, 8'h77);      // slave 2, 3 waits, one wren
    core_access(16'h2100, 1'b0, 8'hC3);
    core_access(16'h9000, 1'b1, 8'h00);      // slave 2 not driving -> C3
    core_access(16'h7ABC, 1'b1, 8'h00);      // unmapped -> open bus
    core_access(16'h7ABC, 1'b0, 8'h3E);      // unmapped write, select none

    // Full page copy; core strobes during the copy must be ignored.
    drv = 3'b011;
    core_access(TRIG, 1'b0, 8'h02);
    push_dma(8'h02);
    n = 0; ready_bad = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!dma_busy) break;
      n++;
      if (core_ready) ready_bad++;
      if (n == 10) begin
        core_addr = TRIG; core_rdwr = 1'b0; core_wdata = 8'h07; core_phy2 = 1'b1;
      end
      if (n == 30) core_phy2 = 1'b0;
    end
    check("dma_cycles", n, 513);
    check("dma_ready_low", ready_bad, 0);
    check("dma_done_ready", core_ready, 1);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      drv = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      if (a == TRIG) a = 16'h4015;
      core_access(a, 1'($urandom), 8'($urandom));
    end

    // Reset in the middle of a copy.
    drv = 3'b001;
    core_access(TRIG, 1'b0, 8'h05);
    push_dma(8'h05);
    n = 0;
    for (int c = 0; c < 1000 && n < 100; c++) begin
      @(negedge clk);
      if (slv_wren && dma_busy) n++;
    end
    check("dma_writes_before_rst", n, 100);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_wren",  slv_wren, 0);
      check("midrst_rden",  slv_rden, 0);
      check("midrst_busy",  dma_busy, 0);
      check("midrst_ready", core_ready, 1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr_q.delete(); dma_rd_q.delete(); rd_q.delete();
    ob = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("after_rst_busy",  dma_busy, 0);
      check("after_rst_ready", core_ready, 1);
      check("after_rst_wren",  slv_wren, 0);
    end
    core_access(16'h9000, 1'b1, 8'h00);      // latch cleared -> 00

    @(negedge clk);
    check("wr_q_drained",     wr_q.size(), 0);
    check("dma_rd_q_drained", dma_rd_q.size(), 0);
    check("rd_q_drained",     rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
